// File: rtl/seg7_to_hex_if.sv
// Segment bus plus decoded readback for the seven-segment decoder.
// master drives the segments, slave is the decoder producing the readback.
interface seg7_to_hex_if;
  logic [6:0] display;
  logic [3:0] num;
  logic       valid;
  logic       blank;
  logic       update;
  logic       err;
  logic [7:0] change_count;

  modport master (output display, input num, valid, blank, update, err, change_count);
  modport slave  (input display, output num, valid, blank, update, err, change_count);
endinterface

// File: rtl/seg7_to_hex.sv
// Active-low seven-segment readback: debounce a pattern for STABLE_CYCLES edges,
// then lock it as a hex digit, blank or illegal pattern.
module seg7_to_hex #(
  parameter int STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          reset,
  seg7_to_hex_if.slave bus
);
  localparam int             CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  SMAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {EMPTY, DIGIT, BLANK, ILLEGAL} state_t;

  state_t        state_q, state_d;
  logic [6:0]    sample, cand, lit;
  logic [CW-1:0] cnt, cnt_d;
  logic          mismatch, qualify, legal, is_blank;
  logic [3:0]    dec;
  logic [3:0]    num_q, num_d;
  logic          valid_q, valid_d, blank_q, blank_d;
  logic          update_q, update_d, err_q, err_d;
  logic [7:0]    cc_q, cc_d;

  always_comb begin
    mismatch = sample != cand;
    cnt_d    = mismatch ? CW'(1) : ((cnt == SMAX) ? cnt : cnt + CW'(1));
    qualify  = (cnt_d == SMAX) && (mismatch || cnt != SMAX);
  end

  // A qualify only happens when cand ends up equal to sample, so decode sample.
  always_comb begin
    lit      = ~sample;
    is_blank = sample == 7'h7F;
    legal    = 1'b1;
    dec      = 4'h0;
    case (lit)
      7'b0111111: dec = 4'h0;
      7'b0000110: dec = 4'h1;
      7'b1011011: dec = 4'h2;
      7'b1001111: dec = 4'h3;
      7'b1100110: dec = 4'h4;
      7'b1101101: dec = 4'h5;
      7'b1111101: dec = 4'h6;
      7'b0000111: dec = 4'h7;
      7'b1111111: dec = 4'h8;
      7'b1100111: dec = 4'h9;
      7'b1110111: dec = 4'hA;
      7'b1111100: dec = 4'hB;
      7'b0111001: dec = 4'hC;
      7'b1011110: dec = 4'hD;
      7'b1111001: dec = 4'hE;
      7'b1110001: dec = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    cc_d     = cc_q;
    if (qualify) begin
      if (is_blank) begin
        state_d = BLANK;
        valid_d = 1'b0;
        blank_d = 1'b1;
      end else if (legal) begin
        state_d = DIGIT;
        num_d   = dec;
        valid_d = 1'b1;
        blank_d = 1'b0;
        if (state_q != DIGIT || dec != num_q) begin
          update_d = 1'b1;
          if (cc_q != 8'hFF) cc_d = cc_q + 8'd1;
        end
      end else begin
        state_d = ILLEGAL;
        valid_d = 1'b0;
        blank_d = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample   <= 7'h7F;
      cand     <= 7'h7F;
      cnt      <= '0;
      state_q  <= EMPTY;
      num_q    <= 4'h0;
      valid_q  <= 1'b0;
      blank_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      cc_q     <= 8'h00;
    end else begin
      sample   <= bus.display;
      cand     <= sample;
      cnt      <= cnt_d;
      state_q  <= state_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      update_q <= update_d;
      err_q    <= err_d;
      cc_q     <= cc_d;
    end
  end

  assign bus.num          = num_q;
  assign bus.valid        = valid_q;
  assign bus.blank        = blank_q;
  assign bus.update       = update_q;
  assign bus.err          = err_q;
  assign bus.change_count = cc_q;
endmodule

// File: tb/tb_seg7_to_hex.sv
// Directed bench for seg7_to_hex: one instance at STABLE_CYCLES=4, one at 1.
module tb_seg7_to_hex;
  logic clk = 1'b0;
  logic rst4, rst1;
  always #5 clk = ~clk;

  seg7_to_hex_if b4();
  seg7_to_hex_if b1();

  seg7_to_hex #(.STABLE_CYCLES(4)) u4 (.clk(clk), .reset(rst4), .bus(b4));
  seg7_to_hex #(.STABLE_CYCLES(1)) u1 (.clk(clk), .reset(rst1), .bus(b1));

  int total = 0;
  int bad   = 0;
  int ups4, errs4, ups1;

  // active-low raw codes for digits 0..F
  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      ups4  += int'(b4.update);
      errs4 += int'(b4.err);
      ups1  += int'(b1.update);
    end
  endtask

  initial begin
    rst4 = 1'b1; rst1 = 1'b1;
    b4.display = 7'h7F; b1.display = 7'h7F;
    ups4 = 0; errs4 = 0; ups1 = 0;
    tick(2);
    chk("rst_num",   int'(b4.num), 0);
    chk("rst_valid", int'(b4.valid), 0);
    chk("rst_blank", int'(b4.blank), 0);
    chk("rst_upd",   int'(b4.update), 0);
    chk("rst_err",   int'(b4.err), 0);
    chk("rst_cc",    int'(b4.change_count), 0);

    // first digit: qualifies on the fifth edge after it is driven
    rst4 = 1'b0; b4.display = seg[2]; ups4 = 0;
    tick(4);
    chk("d2_early", ups4, 0);
    tick(1);
    chk("d2_upd",   int'(b4.update), 1);
    chk("d2_num",   int'(b4.num), 2);
    chk("d2_valid", int'(b4.valid), 1);
    chk("d2_cc",    int'(b4.change_count), 1);
    tick(1);
    chk("d2_pulse", int'(b4.update), 0);

    // short glitch to 8 is ignored, 2 requalifies silently
    ups4 = 0;
    b4.display = seg[8]; tick(2);
    b4.display = seg[2]; tick(8);
    chk("glitch_ups", ups4, 0);
    chk("glitch_num", int'(b4.num), 2);
    chk("glitch_cc",  int'(b4.change_count), 1);

    // blank, then back to 2
    b4.display = 7'h7F; tick(8);
    chk("blk_blank", int'(b4.blank), 1);
    chk("blk_valid", int'(b4.valid), 0);
    chk("blk_num",   int'(b4.num), 2);
    b4.display = seg[2]; ups4 = 0; tick(5);
    chk("unblk_ups",   ups4, 1);
    chk("unblk_cc",    int'(b4.change_count), 2);
    chk("unblk_valid", int'(b4.valid), 1);
    chk("unblk_blank", int'(b4.blank), 0);

    // illegal pattern while locked on 5
    b4.display = seg[5]; tick(6);
    chk("d5_num", int'(b4.num), 5);
    chk("d5_cc",  int'(b4.change_count), 3);
    b4.display = 7'b1111110; errs4 = 0; ups4 = 0;
    tick(4);
    chk("ill_early", errs4, 0);
    tick(1);
    chk("ill_err",   int'(b4.err), 1);
    chk("ill_valid", int'(b4.valid), 0);
    chk("ill_blank", int'(b4.blank), 0);
    chk("ill_num",   int'(b4.num), 5);
    tick(6);
    chk("ill_errs", errs4, 1);
    chk("ill_ups",  ups4, 0);
    chk("ill_cc",   int'(b4.change_count), 3);

    // reset while 7 is half-way through qualification
    b4.display = seg[7]; tick(3);
    rst4 = 1'b1; tick(1);
    chk("mid_num",   int'(b4.num), 0);
    chk("mid_valid", int'(b4.valid), 0);
    chk("mid_blank", int'(b4.blank), 0);
    chk("mid_err",   int'(b4.err), 0);
    chk("mid_cc",    int'(b4.change_count), 0);
    rst4 = 1'b0; ups4 = 0;
    tick(4);
    chk("re7_early", ups4, 0);
    tick(1);
    chk("re7_upd", int'(b4.update), 1);
    chk("re7_num", int'(b4.num), 7);
    chk("re7_cc",  int'(b4.change_count), 1);

    // blank held through reset release qualifies one edge early
    rst4 = 1'b1; b4.display = 7'h7F; tick(1);
    rst4 = 1'b0; tick(3);
    chk("rb_early", int'(b4.blank), 0);
    tick(1);
    chk("rb_blank", int'(b4.blank), 1);
    chk("rb_valid", int'(b4.valid), 0);
    chk("rb_upd",   int'(b4.update), 0);

    // STABLE_CYCLES=1: blank at the first edge, then sweep all digits
    rst1 = 1'b0; tick(1);
    chk("s1_blank", int'(b1.blank), 1);
    ups1 = 0;
    for (int i = 0; i < 16; i++) begin
      b1.display = seg[i];
      tick(3);
      chk($sformatf("s1_num%0d", i), int'(b1.num), i);
    end
    chk("s1_ups", ups1, 16);
    chk("s1_cc",  int'(b1.change_count), 16);

    ups1 = 0;
    for (int k = 0; k < 284; k++) begin
      b1.display = k[0] ? seg[1] : seg[0];
      tick(2);
      if (k == 237) chk("s1_cc254", int'(b1.change_count), 254);
    end
    chk("sat_ups", ups1, 284);
    chk("sat_cc",  int'(b1.change_count), 255);
    chk("sat_num", int'(b1.num), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_to_hex.md
# seg7_to_hex

Seven-segment pattern decoder for the timer display path: the inverse of the hex-to-7-segment encoder. It samples an active-low segment bus, waits until a pattern has been stable for a programmable number of cycles, and decodes it back into a 4-bit hex digit. It also reports blank and illegal patterns. Used by the self-check logic and the bench to read back what the display drivers are actually showing.

## Interface

Parameters:
- STABLE_CYCLES, 4, consecutive matching cycles required to qualify a pattern; legal range 1..255. The counter width is $clog2(STABLE_CYCLES+1).

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- display  in  7  active-low segments; bit0=a … bit6=g (a segment is lit when its bit is 0)
- num  out  4  last qualified legal digit, 0x0..0xF
- valid  out  1  level; 1 while the current locked pattern is a legal digit
- blank  out  1  level; 1 while the current locked pattern is all-off (7'h7F)
- update  out  1  one-cycle pulse when num/valid take a new digit
- err  out  1  one-cycle pulse when an illegal pattern qualifies
- change_count  out  8  saturating count of update pulses

## Operation

- Legal table, with raw display values equal to the bitwise inverse of the lit pattern gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- All-off (7'h7F) is BLANK. Every other pattern is ILLEGAL.
- Input stage: `sample <= display` every cycle, one register and no other filtering.
- Stability filter, evaluated each edge:
  - If `sample != cand`: `cand <= sample`, `cnt <= 1`.
  - Otherwise: `cnt <= min(cnt+1, STABLE_CYCLES)`.
- Qualify event: the new cnt equals STABLE_CYCLES and the old cnt did not. This includes the mismatch case when STABLE_CYCLES=1. Once saturated, cnt does not re-qualify.
- Lock state machine, updated on a qualify event only:
  - States: EMPTY (reset), DIGIT, BLANK, ILLEGAL.
  - To DIGIT: `num <= decode(cand)`, `valid <= 1`, `blank <= 0`. `update` pulses if the previous state was not DIGIT or the decoded value differs from num. Re-qualifying the same digit from DIGIT gives no pulse.
  - To BLANK: `valid <= 0`, `blank <= 1`, num holds.
  - To ILLEGAL: `valid <= 0`, `blank <= 0`, num holds, `err` pulses. Every illegal qualification pulses err, even illegal→illegal.
- change_count increments on each update and saturates at 255.
- No qualify event means no change to any output except that update and err return to 0.

## Timing

- Reset values: num=0, valid=0, blank=0, update=0, err=0, change_count=0, state=EMPTY, sample=cand=7'h7F, cnt=0.
- Reset asserted mid-qualification or mid-lock clears everything at that edge. Reset has priority over all updates.
- Latency: a new value first sampled at edge E0 loads cand at E1 and qualifies at E_S (S=STABLE_CYCLES). The outputs are valid immediately after E_S, i.e. S+1 rising edges from the first sample.
- A pattern that lasts fewer edges than this is ignored. When the pattern reverts, the filter restarts against the reverted value.
- Blank held through reset release: the reset values already match, so BLANK qualifies at edge E_{S-1}, where E0 is the first edge with reset low.
- update and err are registered outputs, high for exactly one cycle, and never high together.

## Test plan

- S=4, reset, then display=7'b0100100 (digit 2) held → after edge E4: update=1 for one cycle, num=2, valid=1, change_count=1.
- Locked on 2, then 7'b0000000 (digit 8) for 2 cycles, then back to 2 → no update, num=2, change_count unchanged.
- Locked on 2 → blank for 8 cycles → 2 → blank=1 and valid=0 during the blank; then update pulses again and change_count=2.
- Locked on 5 → 7'b1111110 (segment a only) held → err=1 for one cycle, valid=0, blank=0, num stays 5, change_count unchanged; no second err while held.
- S=1, step through all 16 legal patterns, 3 cycles each → num follows 0..F, 16 update pulses, change_count=16. Patterns 6 (0000010) and b (0000011) decode distinctly. Continue alternating two digits to reach 300 updates → change_count saturates at 255.
- S=4, digit 7 held with reset pulsed at cnt=2 → all outputs zero after the reset edge; 7 then re-qualifies S+1 edges after its first post-reset sample, with change_count=1.
